// File: rtl/l2_cache_if.sv
// Bus bundle between the L1 side (wishbone slave port of the cache) and physical memory
// (wishbone master port of the cache). The cache uses the slave modport; a bench or an L1/memory pair uses master.
interface l2_cache_if;
  logic         cpu_cyc;
  logic         cpu_stb;
  logic         cpu_we;
  logic [15:0]  cpu_sel;
  logic [11:0]  cpu_adr;
  logic [127:0] cpu_dat_i;
  logic [127:0] cpu_dat_o;
  logic         cpu_ack;
  logic         cpu_rty;
  logic         mem_cyc;
  logic         mem_stb;
  logic         mem_we;
  logic [15:0]  mem_sel;
  logic [11:0]  mem_adr;
  logic [127:0] mem_dat_o;
  logic [127:0] mem_dat_i;
  logic         mem_ack;
  logic         mem_rty;

  modport slave (
    input  cpu_cyc, cpu_stb, cpu_we, cpu_sel, cpu_adr, cpu_dat_i, mem_dat_i, mem_ack, mem_rty,
    output cpu_dat_o, cpu_ack, cpu_rty, mem_cyc, mem_stb, mem_we, mem_sel, mem_adr, mem_dat_o
  );

  modport master (
    output cpu_cyc, cpu_stb, cpu_we, cpu_sel, cpu_adr, cpu_dat_i, mem_dat_i, mem_ack, mem_rty,
    input  cpu_dat_o, cpu_ack, cpu_rty, mem_cyc, mem_stb, mem_we, mem_sel, mem_adr, mem_dat_o
  );
endinterface

// File: rtl/l2_cache_core.sv
// 2-way set-associative write-back/write-allocate L2 engine with 128-bit lines and 12-bit line addresses.
// Optional hit/miss counters are compiled in with L2_PERF_COUNTERS_EN.
//
// state    | meaning
// IDLE     | serve hits combinationally; a miss latches victim and address
// WRITEBACK| write dirty victim line back to memory
// FETCH    | fill victim way from memory, then return to IDLE where the request hits
module l2_cache_core #(
  parameter int SETS_LOG2 = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  l2_cache_if.slave    bus
`ifdef L2_PERF_COUNTERS_EN
  ,
  output logic [15:0]  l2_miss_counter,
  output logic [15:0]  l2_hit_counter
`endif
);

  localparam int SETS = 1 << SETS_LOG2;
  localparam int TW   = 12 - SETS_LOG2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WB    = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  victim_q, victim_d;
  logic [11:0]           miss_adr_q, miss_adr_d;
  logic [1:0][SETS-1:0]  valid_q, valid_d;
  logic [1:0][SETS-1:0]  dirty_q, dirty_d;
  logic [SETS-1:0]       lru_q, lru_d;
  logic [127:0]          data_q [2][SETS];
  logic [TW-1:0]         tag_q  [2][SETS];

  logic [SETS_LOG2-1:0]  idx, m_idx, data_idx;
  logic [TW-1:0]         tag, m_tag;
  logic                  hit0, hit1, hit, req, mem_done;
  logic [127:0]          hit_line, merged, data_wd;
  logic                  data_we, data_way, tag_we;

  assign idx   = bus.cpu_adr[SETS_LOG2-1:0];
  assign tag   = bus.cpu_adr[11:SETS_LOG2];
  assign m_idx = miss_adr_q[SETS_LOG2-1:0];
  assign m_tag = miss_adr_q[11:SETS_LOG2];

  assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1     = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit      = hit0 | hit1;
  assign req      = bus.cpu_cyc & bus.cpu_stb;
  // A retry response outranks a simultaneous ack: the request is simply held.
  assign mem_done = bus.mem_ack & ~bus.mem_rty;
  assign hit_line = hit1 ? data_q[1][idx] : data_q[0][idx];

  assign bus.cpu_dat_o = hit_line;
  assign bus.cpu_rty   = req & ~bus.cpu_ack;
  assign bus.mem_sel   = '1;

  always_comb begin
    merged = hit_line;
    for (int i = 0; i < 16; i++) begin
      if (bus.cpu_sel[i]) merged[8*i +: 8] = bus.cpu_dat_i[8*i +: 8];
    end
  end

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    miss_adr_d    = miss_adr_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    lru_d         = lru_q;
    data_we       = 1'b0;
    data_way      = hit1;
    data_idx      = idx;
    data_wd       = merged;
    tag_we        = 1'b0;
    bus.cpu_ack   = 1'b0;
    bus.mem_cyc   = 1'b0;
    bus.mem_stb   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_adr   = miss_adr_q;
    bus.mem_dat_o = '0;
    case (state_q)
      S_IDLE: begin
        if (req && hit) begin
          bus.cpu_ack = 1'b1;
          lru_d[idx]  = ~hit1;
          if (bus.cpu_we) begin
            data_we             = 1'b1;
            dirty_d[hit1][idx]  = 1'b1;
          end
        end else if (req) begin
          victim_d   = lru_q[idx];
          miss_adr_d = bus.cpu_adr;
          state_d    = (valid_q[lru_q[idx]][idx] && dirty_q[lru_q[idx]][idx]) ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        bus.mem_cyc   = 1'b1;
        bus.mem_stb   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_adr   = {tag_q[victim_q][m_idx], m_idx};
        bus.mem_dat_o = data_q[victim_q][m_idx];
        if (mem_done) begin
          dirty_d[victim_q][m_idx] = 1'b0;
          state_d                  = S_FETCH;
        end
      end
      S_FETCH: begin
        bus.mem_cyc = 1'b1;
        bus.mem_stb = 1'b1;
        if (mem_done) begin
          data_we                  = 1'b1;
          data_way                 = victim_q;
          data_idx                 = m_idx;
          data_wd                  = bus.mem_dat_i;
          tag_we                   = 1'b1;
          valid_d[victim_q][m_idx] = 1'b1;
          dirty_d[victim_q][m_idx] = 1'b0;
          state_d                  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      victim_q   <= 1'b0;
      miss_adr_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      lru_q      <= '0;
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      miss_adr_q <= miss_adr_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      lru_q      <= lru_d;
    end
  end

  // Line and tag storage is deliberately not reset; valid bits gate its use.
  always_ff @(posedge clk) begin
    if (data_we) data_q[data_way][data_idx] <= data_wd;
    if (tag_we)  tag_q[victim_q][m_idx]     <= m_tag;
  end

`ifdef L2_PERF_COUNTERS_EN
  logic [15:0] miss_cnt_q, miss_cnt_d, total_q, total_d;

  always_comb begin
    miss_cnt_d = miss_cnt_q + {15'd0, bus.mem_ack & bus.mem_cyc & ~bus.mem_we};
    total_d    = total_q + {15'd0, bus.cpu_ack};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt_q <= '0;
      total_q    <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
      total_q    <= total_d;
    end
  end

  assign l2_miss_counter = miss_cnt_q;
  assign l2_hit_counter  = total_q - miss_cnt_q;
`endif

endmodule

// File: tb/tb_l2_cache_core.sv
// Directed bench for l2_cache_core: cold miss, hits, byte-masked write, dirty eviction,
// memory retry hold and reset during a fill. Counter checks apply when L2_PERF_COUNTERS_EN is defined.
module tb_l2_cache_core;
  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;

  l2_cache_if b ();

`ifdef L2_PERF_COUNTERS_EN
  logic [15:0] miss_cnt;
  logic [15:0] hit_cnt;
`endif

  l2_cache_core #(.SETS_LOG2(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (b)
`ifdef L2_PERF_COUNTERS_EN
    ,
    .l2_miss_counter (miss_cnt),
    .l2_hit_counter  (hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [11:0] a, input logic we, input logic [15:0] sel, input logic [127:0] d);
    b.cpu_cyc   = 1'b1;
    b.cpu_stb   = 1'b1;
    b.cpu_we    = we;
    b.cpu_sel   = sel;
    b.cpu_adr   = a;
    b.cpu_dat_i = d;
  endtask

  task automatic bus_idle();
    b.cpu_cyc = 1'b0;
    b.cpu_stb = 1'b0;
    b.cpu_we  = 1'b0;
  endtask

  logic [127:0] d_line, e_line, f_line, g_line, w_line, m_line;

  initial begin
    clk     = 1'b0;
    vectors = 0;
    errors  = 0;
    d_line  = 128'h0123456789ABCDEFFEDCBA9876543210;
    e_line  = 128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF;
    f_line  = 128'hF00DF00DF00DF00DF00DF00DF00DF00D;
    g_line  = 128'h66666666777777778888888899999999;
    w_line  = 128'h5555555555555555555555555555BEEF;
    m_line  = {d_line[127:16], 16'hBEEF};
    bus_idle();
    b.cpu_sel   = '0;
    b.cpu_adr   = '0;
    b.cpu_dat_i = '0;
    b.mem_ack   = 1'b0;
    b.mem_rty   = 1'b0;
    b.mem_dat_i = '0;
    rst_n       = 1'b0;

    #1;
    chk("rst_cpu_ack", b.cpu_ack, 0);
    chk("rst_mem_cyc", b.mem_cyc, 0);
    chk("rst_mem_stb", b.mem_stb, 0);
    chk("rst_mem_we",  b.mem_we,  0);
    chk("rst_cpu_rty", b.cpu_rty, 0);
    chk("rst_mem_sel", b.mem_sel, 16'hFFFF);
`ifdef L2_PERF_COUNTERS_EN
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_hit_cnt",  hit_cnt,  0);
`endif
    @(negedge clk); rst_n = 1'b1;

    // cold read of 0x012: miss, no ack
    @(negedge clk); req(12'h012, 1'b0, 16'h0000, '0);
    #1;
    chk("cold_ack",    b.cpu_ack, 0);
    chk("cold_rty",    b.cpu_rty, 1);
    chk("cold_memcyc", b.mem_cyc, 0);

    @(negedge clk); #1;
    chk("fetch0_cyc", b.mem_cyc, 1);
    chk("fetch0_stb", b.mem_stb, 1);
    chk("fetch0_we",  b.mem_we,  0);
    chk("fetch0_adr", b.mem_adr, 12'h012);
    chk("fetch0_ack", b.cpu_ack, 0);
    b.mem_ack = 1'b1; b.mem_dat_i = d_line;

    @(negedge clk); b.mem_ack = 1'b0; #1;
    chk("fill0_ack", b.cpu_ack, 1);
    chk("fill0_dat", b.cpu_dat_o, d_line);
    chk("fill0_rty", b.cpu_rty, 0);

    // repeat read: same-cycle hit, no memory traffic
    @(negedge clk); #1;
`ifdef L2_PERF_COUNTERS_EN
    chk("cnt1_miss", miss_cnt, 1);
    chk("cnt1_hit",  hit_cnt,  0);
`endif
    chk("rep_ack",    b.cpu_ack, 1);
    chk("rep_memcyc", b.mem_cyc, 0);
    chk("rep_dat",    b.cpu_dat_o, d_line);

    // write hit, low two bytes only
    @(negedge clk);
`ifdef L2_PERF_COUNTERS_EN
    chk("cnt2_hit", hit_cnt, 1);
`endif
    req(12'h012, 1'b1, 16'h0003, w_line);
    #1;
    chk("wr_ack",    b.cpu_ack, 1);
    chk("wr_memcyc", b.mem_cyc, 0);

    @(negedge clk); req(12'h012, 1'b0, 16'h0000, '0); #1;
    chk("rdback_ack", b.cpu_ack, 1);
    chk("rdback_dat", b.cpu_dat_o, m_line);

    // 0x022 fills the other way of set 2
    @(negedge clk); req(12'h022, 1'b0, 16'h0000, '0); #1;
    chk("miss1_ack", b.cpu_ack, 0);
    @(negedge clk); #1;
    chk("fetch1_adr", b.mem_adr, 12'h022);
    chk("fetch1_we",  b.mem_we,  0);
    b.mem_ack = 1'b1; b.mem_dat_i = e_line;
    @(negedge clk); b.mem_ack = 1'b0; #1;
    chk("fill1_ack", b.cpu_ack, 1);
    chk("fill1_dat", b.cpu_dat_o, e_line);

    // 0x032 evicts dirty LRU line 0x012
    @(negedge clk); req(12'h032, 1'b0, 16'h0000, '0); #1;
    chk("miss2_ack", b.cpu_ack, 0);
    @(negedge clk); #1;
    chk("wb_cyc", b.mem_cyc, 1);
    chk("wb_we",  b.mem_we,  1);
    chk("wb_adr", b.mem_adr, 12'h012);
    chk("wb_dat", b.mem_dat_o, m_line);
    chk("wb_rty", b.cpu_rty, 1);
    b.mem_ack = 1'b1;

    @(negedge clk); b.mem_ack = 1'b0; b.mem_rty = 1'b1; #1;
    chk("fetch2_adr", b.mem_adr, 12'h032);
    chk("fetch2_we",  b.mem_we,  0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("rty_adr",    b.mem_adr, 12'h032);
      chk("rty_stb",    b.mem_stb, 1);
      chk("rty_cpurty", b.cpu_rty, 1);
      chk("rty_ack",    b.cpu_ack, 0);
    end
    b.mem_rty = 1'b0; b.mem_ack = 1'b1; b.mem_dat_i = f_line;

    @(negedge clk); b.mem_ack = 1'b0; #1;
    chk("fill2_ack", b.cpu_ack, 1);
    chk("fill2_dat", b.cpu_dat_o, f_line);

    @(negedge clk); bus_idle(); #1;
`ifdef L2_PERF_COUNTERS_EN
    chk("cnt3_miss", miss_cnt, 3);
    chk("cnt3_hit",  hit_cnt,  3);
`endif
    chk("idle_ack", b.cpu_ack, 0);
    chk("idle_rty", b.cpu_rty, 0);

    // reset during a fill of 0x042
    @(negedge clk); req(12'h042, 1'b0, 16'h0000, '0); #1;
    chk("miss3_ack", b.cpu_ack, 0);
    @(negedge clk); #1;
    chk("fetch3_cyc", b.mem_cyc, 1);
    chk("fetch3_adr", b.mem_adr, 12'h042);
    rst_n = 1'b0; #1;
    chk("midrst_cyc", b.mem_cyc, 0);
    chk("midrst_stb", b.mem_stb, 0);
`ifdef L2_PERF_COUNTERS_EN
    chk("midrst_miss", miss_cnt, 0);
`endif

    // previously cached 0x032 now misses; clean fetch, no writeback
    @(negedge clk); rst_n = 1'b1; req(12'h032, 1'b0, 16'h0000, '0); #1;
    chk("post_rst_ack", b.cpu_ack, 0);
    @(negedge clk); #1;
    chk("post_rst_we",  b.mem_we,  0);
    chk("post_rst_adr", b.mem_adr, 12'h032);
    b.mem_ack = 1'b1; b.mem_dat_i = g_line;
    @(negedge clk); b.mem_ack = 1'b0; #1;
    chk("post_rst_fill_ack", b.cpu_ack, 1);
    chk("post_rst_fill_dat", b.cpu_dat_o, g_line);

    @(negedge clk); bus_idle();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/l2_cache_core.md
Name: l2_cache_core

Overview:
- 2-way set-associative, write-back, write-allocate L2 cache engine: controller FSM plus tag/valid/dirty/LRU/data arrays.
- Sits between the L1 side (wishbone slave, 128-bit lines) and physical memory (wishbone master, 128-bit lines).
- Addresses are 12-bit line addresses (byte address [15:4]).

Parameters:
- SETS_LOG2, 3, log2 of set count. Index = adr[SETS_LOG2-1:0]; tag = adr[11:SETS_LOG2], width 12-SETS_LOG2.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_cyc  in  1  wishbone cycle from L1.
- cpu_stb  in  1  wishbone strobe from L1.
- cpu_we  in  1  1=write, 0=read.
- cpu_sel  in  16  byte enables for writes; bit i covers data bits [8i+7:8i].
- cpu_adr  in  12  line address.
- cpu_dat_i  in  128  write data.
- cpu_dat_o  out  128  read data: hit line.
- cpu_ack  out  1  request complete.
- cpu_rty  out  1  cpu_cyc & cpu_stb & ~cpu_ack.
- mem_cyc  out  1  memory cycle.
- mem_stb  out  1  memory strobe.
- mem_we  out  1  1=writeback, 0=fill.
- mem_sel  out  16  constant all ones.
- mem_adr  out  12  memory line address.
- mem_dat_o  out  128  writeback data.
- mem_dat_i  in  128  fill data.
- mem_ack  in  1  memory done.
- mem_rty  in  1  memory busy; request is held unchanged.

Behaviour:
- Reset (async, rst_n=0):
  - all valid, dirty and LRU bits cleared; FSM to IDLE.
  - cpu_ack, mem_cyc, mem_stb, mem_we = 0.
  - Data/tag arrays not cleared.
- hit0 = valid0 & tag0==tag. hit1 likewise. hit = hit0|hit1.
- FSM states: IDLE, WRITEBACK, FETCH.
- IDLE:
  - With cpu_cyc&cpu_stb&hit: cpu_ack=1 combinationally the same cycle; cpu_dat_o = hit way's line.
  - If cpu_we, at the clock edge merge cpu_dat_i into the hit way per cpu_sel and set that way's dirty=1.
  - LRU[set] updated on every hit to point to the other way (lru=1 means way1 is victim).
  - With cpu_cyc&cpu_stb&~hit: victim = way LRU[set].
  - Go to WRITEBACK if victim valid&dirty, else FETCH. No ack this cycle.
- WRITEBACK:
  - Outputs: mem_cyc=mem_stb=mem_we=1, mem_adr={victim tag,index}, mem_dat_o = victim line.
  - On mem_ack: clear victim dirty; go to FETCH.
- FETCH:
  - Outputs: mem_cyc=mem_stb=1, mem_we=0, mem_adr=cpu_adr.
  - On mem_ack: write mem_dat_i into victim way data, tag=cpu tag, valid=1, dirty=0; go to IDLE.
  - The request then hits and is acked one cycle after fill (miss latency = memory latency(s) + 1).
- mem_rty: no state change; keep outputs stable until mem_ack.
- Victim selection is latched on miss entry. The in-progress miss completes even if cpu_stb drops mid-miss; the fill is kept.
- Invalid ways are never hits. When both ways are invalid, LRU=0 selects way0.
- Reset mid-miss: memory cycle abandoned immediately (mem_cyc=0); arrays invalidated.
- Outside IDLE: cpu_ack=0, so cpu_rty=1 while the request is pending.

Optional Feature:
- Macro L2_PERF_COUNTERS_EN.
- Defined: adds outputs l2_miss_counter[15:0] and l2_hit_counter[15:0].
  - miss increments on each clk edge with mem_ack&mem_cyc&~mem_we.
  - An internal total increments on each edge with cpu_ack.
  - hit = total - miss, modulo 2^16.
  - Both counters wrap at 16 bits and reset to 0 on rst_n.
- Undefined: ports and logic absent; cache behaviour identical.

Test Plan:
- Cold read of adr 0x012 (after reset):
  - -> FETCH with mem_adr=0x012, mem_we=0.
  - mem_ack with data D -> cpu_ack one cycle later, cpu_dat_o=D; counters miss=1, hit=0.
- Repeat read of 0x012 -> cpu_ack same cycle as strobe, no mem_cyc, data D; hit=1.
- Write hit to 0x012, cpu_sel=0x0003, data 0xBEEF in low bytes:
  - -> ack same cycle.
  - Next read returns D with bits[15:0]=0xBEEF.
- Set conflict:
  - Read 0x022, then read 0x032 (same set 2, both ways full).
  - -> 0x012 (dirty, LRU) evicted: WRITEBACK mem_adr=0x012, mem_we=1, merged line.
  - Then FETCH 0x032.
- Hold mem_rty=1 and mem_ack=0 for 5 cycles during FETCH -> mem_adr/mem_stb stable, cpu_rty=1 throughout, no ack.
- Assert rst_n=0 mid-FETCH:
  - -> mem_cyc=0 immediately.
  - Subsequent read of a previously cached line misses.
